fetch_stage: RTL and testbench

//  Instruction-fetch stage of the segmented ARMv8 core; sits directly upstream of decode (IF/ID).

---
 rtl/arm_core_pkg.sv | 7 +
 rtl/fetch_skid_fifo.sv | 41 ++++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_core_pkg.sv
// Shared widths and constants for the segmented ARMv8 core.
package arm_core_pkg;
    localparam int          ADDR_W           = 64;
    localparam int          INST_W           = 32;
    localparam logic [31:0] NOP_INST         = 32'hD503201F;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO that absorbs decode stalls between instruction memory and IF/ID.
module fetch_skid_fifo #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, synchronous imem requests, epoch-based kill and
// a skid buffer feeding decode over valid/ready.
module fetch_stage #(
    parameter int                ADDR_W   = arm_core_pkg::ADDR_W,
    parameter int                INST_W   = arm_core_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = arm_core_pkg::RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              Reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] Inst,
    output logic [ADDR_W-1:0] Address
);
    import arm_core_pkg::*;

    localparam int ENTRY_W = INST_W + ADDR_W;

    logic [ADDR_W-1:0]  pc;
    logic               epoch;
    logic               inflight_valid;
    logic               inflight_epoch;
    logic [ADDR_W-1:0]  inflight_addr;
    logic [ADDR_W-1:0]  last_addr;

    logic [ENTRY_W-1:0] fifo_dout;
    logic [1:0]         fifo_count;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    logic               resp_live;
    logic [INST_W-1:0]  head_inst;
    logic [ADDR_W-1:0]  head_addr;
    logic               handshake;
    logic [2:0]         next_occ;
    logic               issue;

    assign fifo_empty = (fifo_count == 2'd0);
    assign resp_live  = inflight_valid && (inflight_epoch == epoch);

    // The returning response is presented directly while the FIFO is empty,
    // which is what gives the 2-cycle redirect penalty and bubble-free streaming.
    always_comb begin
        head_inst = fifo_dout[ENTRY_W-1:ADDR_W];
        head_addr = fifo_dout[ADDR_W-1:0];
        if (fifo_empty) begin
            head_inst = imem_rdata;
            head_addr = inflight_addr;
        end
    end

    // Handshake: an instruction transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid && !out_ready the offered
    // Inst/Address stay frozen. A redirect in the same cycle voids the transfer.
    assign out_valid = !fifo_empty || resp_live;
    assign Inst      = out_valid ? head_inst : INST_W'(NOP_INST);
    assign Address   = out_valid ? head_addr : last_addr;
    assign handshake = out_valid && out_ready && !redirect;

    assign fifo_pop  = handshake && !fifo_empty;
    assign fifo_push = resp_live && !redirect && !(fifo_empty && handshake);

    // Occupancy after this cycle's push/pop; keeping it plus the new request
    // at or below 2 guarantees every response finds a free slot.
    assign next_occ  = {1'b0, fifo_count} + {2'b00, resp_live} - {2'b00, handshake};
    assign issue     = !Reset && !redirect && (next_occ < 3'd2);
    assign imem_req  = issue;
    assign imem_addr = pc;

    fetch_skid_fifo #(
        .W(ENTRY_W)
    ) u_skid (
        .clk   (clk),
        .reset (Reset),
        .flush (redirect),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({imem_rdata, inflight_addr}),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc             <= RESET_PC;
            epoch          <= 1'b0;
            inflight_valid <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_addr  <= '0;
            last_addr      <= '0;
        end else begin
            if (redirect) begin
                pc    <= redirect_pc & ~ADDR_W'(3);
                epoch <= ~epoch;
            end else if (issue) begin
                pc <= pc + ADDR_W'(4);
            end
            inflight_valid <= issue;
            if (issue) begin
                inflight_addr  <= pc;
                inflight_epoch <= epoch;
            end
            if (out_valid) begin
                last_addr <= head_addr;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model, ordered scoreboard of
// expected delivered addresses, and scenario tasks with inline checks.
module tb_fetch_stage;
  logic        clk;
  logic        Reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Inst;
  logic [63:0] Address;

  int n_checks = 0;
  int n_fail = 0;
  int n_matched = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;

  fetch_stage dut (
    .clk        (clk),
    .Reset      (Reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Inst       (Inst),
    .Address    (Address)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2];
    return w ^ 32'hC0DE_0000 ^ {2'b00, a[63:34]};
  endfunction

  // synchronous instruction memory, 1-cycle latency; garbage when not requested
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= inst_of(imem_addr);
    else imem_rdata <= 32'hDEAD_BEEF;
  end

  // scoreboard: every accepted instruction must be the next expected address
  always @(negedge clk) begin
    if (!Reset && !redirect && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got Address=%h Inst=%h, required no output", Address, Inst);
      end else begin
        sb_exp = exp_q.pop_front();
        n_matched++;
        if (Address !== sb_exp || Inst !== inst_of(sb_exp)) begin
          n_fail++;
          $display("FAIL sb_order: got Address=%h Inst=%h, required Address=%h Inst=%h",
                   Address, Inst, sb_exp, inst_of(sb_exp));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [63:0] start, input int n);
    logic [63:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 64'd4;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || Inst !== arm_core_pkg::NOP_INST || Address !== 64'h0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b Inst=%h Address=%h req=%b, required 0 %h 0 0",
               out_valid, Inst, Address, imem_req, arm_core_pkg::NOP_INST);
    end
    Reset = 1'b0;
    exp_q.delete();
    push_seq(64'h0, 16);
  endtask

  // cycles 0..2 after reset release
  task automatic test_stream();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'(4 * k)) begin
        n_fail++;
        $display("FAIL stream_issue: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, 64'(4 * k));
      end
      if (k > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || Address !== 64'(4 * (k - 1))) begin
          n_fail++;
          $display("FAIL stream_out: got valid=%b Address=%h, required valid=1 Address=%h",
                   out_valid, Address, 64'(4 * (k - 1)));
        end
      end
      next_cycle();
    end
  endtask

  // cycles 3..6 stalled with Address=8 held, then release
  task automatic test_stall();
    out_ready = 1'b0;
    for (int k = 3; k < 7; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || Address !== 64'h8 || Inst !== inst_of(64'h8)) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%b Address=%h Inst=%h, required valid=1 Address=8", out_valid, Address, Inst);
      end
      if (k == 3) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'hC) begin
          n_fail++;
          $display("FAIL stall_last_issue: got req=%b addr=%h, required req=1 addr=c", imem_req, imem_addr);
        end
      end
      if (k >= 5) begin
        n_checks++;
        if (imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_no_issue: got req=%b, required 0", imem_req);
        end
      end
      next_cycle();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL release_bubble: got valid=%b, required 1", out_valid);
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    repeat (3) next_cycle();
    redirect = 1'b1;
    redirect_pc = 64'h100;
    out_ready = 1'b1;
    exp_q.delete();
    push_seq(64'h100, 16);
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_no_issue: got req=%b, required 0", imem_req);
    end
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
      n_fail++;
      $display("FAIL redir_n1: got valid=%b req=%b addr=%h, required 0 1 100", out_valid, imem_req, imem_addr);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || Address !== 64'h100 || Inst !== inst_of(64'h100)) begin
      n_fail++;
      $display("FAIL redir_n2: got valid=%b Address=%h Inst=%h, required 1 100 %h", out_valid, Address, Inst, inst_of(64'h100));
    end
    next_cycle();
    repeat (4) next_cycle();
  endtask

  task automatic test_redirect_align();
    redirect = 1'b1;
    redirect_pc = 64'h103;
    exp_q.delete();
    push_seq(64'h100, 8);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin
      n_fail++;
      $display("FAIL align_addr: got req=%b addr=%h, required 1 100", imem_req, imem_addr);
    end
    next_cycle();
    repeat (3) next_cycle();
    redirect = 1'b1;
    redirect_pc = 64'h200;
    exp_q.delete();
    push_seq(64'h300, 8);
    next_cycle();
    redirect_pc = 64'h300;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_squash: got req=%b valid=%b, required 0 0", imem_req, out_valid);
    end
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h300) begin
      n_fail++;
      $display("FAIL b2b_issue: got valid=%b req=%b addr=%h, required 0 1 300", out_valid, imem_req, imem_addr);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || Address !== 64'h300) begin
      n_fail++;
      $display("FAIL b2b_first: got valid=%b Address=%h, required 1 300", out_valid, Address);
    end
    next_cycle();
    repeat (3) next_cycle();
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    exp_q.delete();
    push_seq(64'hFFFF_FFFF_FFFF_FFF8, 8);
    next_cycle();
    redirect = 1'b0;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_top: got addr=%h, required fffffffffffffffc", imem_addr);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL wrap_zero: got req=%b addr=%h, required 1 0", imem_req, imem_addr);
    end
    next_cycle();
    repeat (4) next_cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    repeat (3) next_cycle();
    Reset = 1'b1;
    exp_q.delete();
    next_cycle();
    n_checks++;
    if (out_valid !== 1'b0 || Inst !== arm_core_pkg::NOP_INST || Address !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b Inst=%h Address=%h, required 0 %h 0", out_valid, Inst, Address, arm_core_pkg::NOP_INST);
    end
    Reset = 1'b0;
    out_ready = 1'b1;
    push_seq(64'h0, 8);
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid_pc: got req=%b addr=%h, required 1 0", imem_req, imem_addr);
    end
    next_cycle();
    repeat (4) next_cycle();
    Reset = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h500;
    exp_q.delete();
    next_cycle();
    Reset = 1'b0;
    redirect = 1'b0;
    push_seq(64'h0, 8);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_redir: got valid=%b req=%b addr=%h, required 0 1 0", out_valid, imem_req, imem_addr);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || Address !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_redir_first: got valid=%b Address=%h, required 1 0", out_valid, Address);
    end
    next_cycle();
    repeat (3) next_cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_align();
    test_wrap();
    test_reset_mid();
    out_ready = 1'b0;
    repeat (2) next_cycle();
    n_checks++;
    if (n_matched < 15) begin
      n_fail++;
      $display("FAIL sb_activity: got %0d accepted instructions, required at least 15", n_matched);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
